instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage upstream of the cpu core. Owns the program counter and issues one
//  instruction-memory read at a time. Presents PC/INSTRUCTION with a valid flag
//  and holds them while the core stalls. Supports taken-branch redirect with
//  flush, plus a response-timeout watchdog.
// PARAMETERS
//  RESET_PC   32'h0  PC value loaded on reset
//  PC_STEP    4      increment applied after each consumed instruction
//  TIMEOUT    16     max cycles REQ->VALID before FETCH_ERR (range 2..255)
// PORTS
//  CLK            in   1   clock, all state on rising edge
//  RESET_N        in   1   asynchronous, active-low reset
//  IMEM_REQ       out  1   one-cycle read request pulse
//  IMEM_ADDR      out  32  read address, valid when IMEM_REQ=1
//  IMEM_READDATA  in   32  returned instruction word, valid with IMEM_VALID
//  IMEM_VALID     in   1   response strobe, >=1 cycle after REQ, in order
//  STALL          in   1   core not accepting current instruction
//  BRANCH_TAKEN   in   1   redirect request, sampled on rising CLK
//  BRANCH_TARGET  in   32  redirect address; bits [1:0] forced to 0
//  PC             out  32  address of INSTRUCTION
//  INSTRUCTION    out  32  instruction word to core
//  INSTR_VALID    out  1   PC/INSTRUCTION valid
//  FETCH_ERR      out  1   sticky: memory timeout occurred
// BEHAVIOUR
//  Reset (async assert): fetch_pc=RESET_PC, PC=RESET_PC, INSTRUCTION=0,
//   INSTR_VALID=0, IMEM_REQ=0, IMEM_ADDR=0, FETCH_ERR=0, state=S_IDLE.
//  States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_FLUSH, S_ERR.
//  S_IDLE : first edge after release -> S_REQ.
//  S_REQ  : IMEM_REQ=1, IMEM_ADDR=fetch_pc for exactly one cycle -> S_WAIT; wdog=0.
//  S_WAIT : on IMEM_VALID: INSTRUCTION<=IMEM_READDATA, PC<=fetch_pc,
//           INSTR_VALID<=1 -> S_HOLD. wdog increments each cycle; reaching
//           TIMEOUT without IMEM_VALID -> FETCH_ERR<=1, -> S_ERR.
//  S_HOLD : accept = INSTR_VALID & ~STALL. On accept: fetch_pc<=fetch_pc+PC_STEP
//           (mod 2^32 wrap), INSTR_VALID<=0 -> S_REQ. Min fetch latency 3 cycles.
//  Redirect (BRANCH_TAKEN=1, any state but S_IDLE/S_ERR, priority over all else):
//           fetch_pc<=target&~3, INSTR_VALID<=0. From S_WAIT, S_REQ -> S_FLUSH
//           (request outstanding); from S_HOLD/S_FLUSH -> S_REQ / stay S_FLUSH.
//  S_FLUSH: waits for IMEM_VALID of stale request, discards data, -> S_REQ; wdog
//           runs as in S_WAIT. IMEM_VALID in the same cycle as redirect is discarded.
//  S_ERR  : outputs frozen, INSTR_VALID=0, no requests; exit only via RESET_N.
//  STALL ignored outside S_HOLD (no instruction to hold). IMEM_VALID outside
//  S_WAIT/S_FLUSH ignored. Reset mid-request: outstanding response discarded
//  because post-reset state is S_IDLE.
// STRUCTURE
//  Shared package cpu_pkg: fetch state enum, PC_WIDTH=32, INSTR_WIDTH=32,
//  RESET_PC default, PC_STEP default (also used by future branch unit).
//  One sub-module: fetch_watchdog (8-bit counter, clear/enable in, expired out).
//  Rest (FSM, PC/instruction registers) lives in instr_fetch_unit.
// TESTING
//  1 Reset release, mem latency 1, STALL=0 -> REQ addrs 0,4,8; PC/INSTRUCTION
//    pairs (0,0x0000000B),(4,0x00010003),(8,0x80020001), one per 3 cycles.
//  2 STALL=1 for 5 cycles while INSTR_VALID -> PC=4/INSTRUCTION held, no IMEM_REQ;
//    release -> next REQ addr 8.
//  3 BRANCH_TAKEN target 0x43 in S_WAIT, stale VALID 2 cycles later -> stale word
//    never appears; next REQ addr 0x40.
//  4 No IMEM_VALID for TIMEOUT=16 cycles -> FETCH_ERR=1 on cycle 16, no further
//    REQ; RESET_N pulse -> FETCH_ERR=0, REQ addr RESET_PC.
//  5 Redirect to 0xFFFFFFFC then consume -> next REQ addr 0x00000000 (wrap).
//  6 RESET_N low mid-S_WAIT, VALID arrives during reset -> INSTR_VALID stays 0,
//    first post-reset REQ addr RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the cpu front end: datapath widths, the reset and
// increment defaults for the program counter, the fetch state encoding and a
// word-alignment helper. The branch unit is expected to reuse PC_STEP_DEFAULT
// and align_word so both sides agree on instruction addressing.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] PC_STEP_DEFAULT  = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FLUSH,
        S_ERR
    } fetch_state_e;

    // Instructions are word aligned; the two low address bits are dropped.
    function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// ---------------------------------------------------------------------------
// fetch_watchdog
// Counts cycles spent waiting for an instruction-memory response and flags
// when the wait has lasted TIMEOUT cycles.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   clear    in   restart the count (a new request is being issued)
//   enable   in   a response is outstanding this cycle
//   expired  out  this is the TIMEOUT-th waiting cycle and the count is live
// ---------------------------------------------------------------------------
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // count_q holds the number of waiting cycles already completed, so the
    // current waiting cycle is number count_q+1.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Saturate so a long wait cannot wrap back under the limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    assign expired = enable && !clear && (count_q >= LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage in front of the cpu core. Owns the fetch program counter,
// issues one instruction-memory read at a time, presents the returned word
// with its address until the core takes it, redirects on taken branches
// (discarding any response already in flight) and latches a sticky error if
// memory stops answering.
// Ports:
//   clk            in   clock, all state on rising edge
//   reset_n        in   asynchronous active-low reset
//   imem_req       out  one-cycle read request pulse
//   imem_addr      out  read address, valid with imem_req
//   imem_readdata  in   returned instruction word
//   imem_valid     in   response strobe, in order, >=1 cycle after request
//   stall          in   core is not accepting the current instruction
//   branch_taken   in   redirect request
//   branch_target  in   redirect address (low two bits ignored)
//   pc             out  address of instruction
//   instruction    out  instruction word to the core
//   instr_valid    out  pc/instruction are valid
//   fetch_err      out  sticky memory-timeout flag
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_STEP_DEFAULT,
    parameter int unsigned         TIMEOUT  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_readdata,
    input  logic                   imem_valid,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic                   fetch_err
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   instr_valid_q, instr_valid_d;
    logic                   imem_req_q, imem_req_d;
    logic [PC_WIDTH-1:0]    imem_addr_q, imem_addr_d;
    logic                   fetch_err_q, fetch_err_d;

    logic wdog_clear;
    logic wdog_enable;
    logic wdog_expired;
    logic redirect;

    // The watchdog restarts with every request and runs while a response is
    // owed, whether that response will be used (S_WAIT) or thrown away (S_FLUSH).
    assign wdog_clear  = (state_q == S_REQ);
    assign wdog_enable = (state_q == S_WAIT) || (state_q == S_FLUSH);

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .expired (wdog_expired)
    );

    assign redirect = branch_taken && (state_q != S_IDLE) && (state_q != S_ERR);

    // Next-state and datapath logic. A redirect is applied last so it wins
    // over accept, response capture and timeout in the same cycle.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        imem_addr_d   = imem_addr_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    instr_d       = imem_readdata;
                    pc_d          = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end else if (wdog_expired) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_ERR;
                end
            end
            S_HOLD: begin
                if (instr_valid_q && !stall) begin
                    fetch_pc_d    = fetch_pc_q + PC_STEP;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            S_FLUSH: begin
                if (imem_valid) begin
                    state_d = S_REQ;
                end else if (wdog_expired) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_ERR;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A response still owed after this cycle must be drained in S_FLUSH.
        // A response arriving in the redirect cycle itself is simply dropped.
        if (redirect) begin
            fetch_pc_d    = align_word(branch_target);
            instr_valid_d = 1'b0;
            pc_d          = pc_q;
            instr_d       = instr_q;
            fetch_err_d   = fetch_err_q;
            if ((state_q == S_REQ) ||
                (((state_q == S_WAIT) || (state_q == S_FLUSH)) && !imem_valid)) begin
                state_d = S_FLUSH;
            end else begin
                state_d = S_REQ;
            end
        end

        // The request pulse is registered so it lines up with the S_REQ cycle.
        imem_req_d = (state_d == S_REQ);
        if (imem_req_d) begin
            imem_addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit with a small memory responder and a
// transaction-level reference model checked every cycle.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_readdata;
    logic        imem_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (32'd4),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_readdata (imem_readdata),
        .imem_valid    (imem_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .fetch_err     (fetch_err)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit mem_on       = 1'b1;
    int mem_lat      = 1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_000B;
            32'h4:   return 32'h0001_0003;
            32'h8:   return 32'h8002_0001;
            default: return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // One clock: advance past the edge, then let the memory model answer
    // due requests and capture any new request.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        imem_valid = 1'b0;
        if ((pend_due.size() > 0) && (pend_due[0] == cyc)) begin
            imem_valid    = 1'b1;
            imem_readdata = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        if (reset_n && imem_req && mem_on) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + mem_lat);
        end
    endtask

    task automatic apply_reset();
        step();
        reset_n      = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        step();
        pend_addr.delete();
        pend_due.delete();
        imem_valid = 1'b0;
        reset_n    = 1'b1;
        cyc        = 0;
    endtask

    task automatic wait_req(input string name, output logic [31:0] addr, output int at);
        bit found;
        found = 1'b0;
        addr  = 32'hDEAD_DEAD;
        at    = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (imem_req) begin
                found = 1'b1;
                addr  = imem_addr;
                at    = cyc;
            end
        end
        if (!found) fail_bound(name);
    endtask

    task automatic wait_valid(input string name, output logic [31:0] p, output logic [31:0] w, output int at);
        bit found;
        found = 1'b0;
        p     = 32'hDEAD_DEAD;
        w     = 32'hDEAD_DEAD;
        at    = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (instr_valid) begin
                found = 1'b1;
                p     = pc;
                w     = instruction;
                at    = cyc;
            end
        end
        if (!found) fail_bound(name);
    endtask

    // Reference model: tracks the address the next request must carry, the
    // one request that may be outstanding, whether its answer is still
    // wanted, the instruction being offered and the timeout.
    logic [31:0] exp_next_addr = RESET_PC;
    logic [31:0] exp_pc        = RESET_PC;
    logic [31:0] exp_instr     = 32'h0;
    logic [31:0] live_addr     = 32'h0;
    bit          exp_valid     = 1'b0;
    bit          exp_err       = 1'b0;
    bit          outstanding   = 1'b0;
    bit          live          = 1'b0;
    bit          redirect_m;
    bit          nv;
    int          wcnt          = 0;

    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            check_output("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            check_output("rst_imem_req", {31'd0, imem_req}, 32'd0);
            check_output("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
            check_output("rst_pc", pc, RESET_PC);
            check_output("rst_instruction", instruction, 32'd0);
            check_output("rst_imem_addr", imem_addr, 32'd0);
            exp_next_addr = RESET_PC;
            exp_valid     = 1'b0;
            exp_err       = 1'b0;
            outstanding   = 1'b0;
            live          = 1'b0;
            wcnt          = 0;
        end else begin
            check_output("mdl_instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
            check_output("mdl_fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
            if (exp_valid) begin
                check_output("mdl_pc", pc, exp_pc);
                check_output("mdl_instruction", instruction, exp_instr);
            end
            if (imem_req) begin
                check_output("mdl_req_addr", imem_addr, exp_next_addr);
                check_output("mdl_req_legal", {29'd0, outstanding, exp_valid, exp_err}, 32'd0);
            end

            redirect_m = branch_taken && !exp_err;
            nv         = exp_valid;
            if (exp_valid && !stall) begin
                nv            = 1'b0;
                exp_next_addr = exp_pc + 32'd4;
            end
            if (imem_req) begin
                outstanding = 1'b1;
                live        = 1'b1;
                live_addr   = exp_next_addr;
                wcnt        = 0;
            end else if (outstanding) begin
                if (imem_valid) begin
                    outstanding = 1'b0;
                    if (live && !redirect_m) begin
                        nv        = 1'b1;
                        exp_pc    = live_addr;
                        exp_instr = mem_word(live_addr);
                    end
                end else begin
                    wcnt++;
                    if ((wcnt >= TIMEOUT) && !redirect_m) begin
                        exp_err     = 1'b1;
                        outstanding = 1'b0;
                    end
                end
            end
            if (redirect_m) begin
                exp_next_addr = {branch_target[31:2], 2'b00};
                live          = 1'b0;
                nv            = 1'b0;
            end
            exp_valid = nv;
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        logic [31:0] a;
        logic [31:0] p;
        logic [31:0] w;
        int          at;
        int          err_at;
        int          req_cnt;

        reset_n       = 1'b0;
        imem_valid    = 1'b0;
        imem_readdata = 32'h0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;

        // Straight-line fetch, memory latency 1.
        apply_reset();
        wait_req("t1_req0", a, at);
        check_output("t1_req0_addr", a, 32'h0);
        check_output("t1_req0_cyc", at, 1);
        wait_valid("t1_val0", p, w, at);
        check_output("t1_pc0", p, 32'h0);
        check_output("t1_ins0", w, 32'h0000_000B);
        check_output("t1_val0_cyc", at, 3);
        wait_req("t1_req1", a, at);
        check_output("t1_req1_addr", a, 32'h4);
        check_output("t1_req1_cyc", at, 4);
        wait_valid("t1_val1", p, w, at);
        check_output("t1_pc1", p, 32'h4);
        check_output("t1_ins1", w, 32'h0001_0003);
        check_output("t1_val1_cyc", at, 6);
        wait_req("t1_req2", a, at);
        check_output("t1_req2_addr", a, 32'h8);
        wait_valid("t1_val2", p, w, at);
        check_output("t1_pc2", p, 32'h8);
        check_output("t1_ins2", w, 32'h8002_0001);
        check_output("t1_val2_cyc", at, 9);

        // Stall holds the second instruction for five cycles.
        apply_reset();
        wait_valid("t2_val0", p, w, at);
        wait_valid("t2_val1", p, w, at);
        check_output("t2_pc1", p, 32'h4);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("t2_hold_pc", pc, 32'h4);
            check_output("t2_hold_ins", instruction, 32'h0001_0003);
            check_output("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
            check_output("t2_hold_noreq", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        wait_req("t2_req", a, at);
        check_output("t2_req_addr", a, 32'h8);
        check_output("t2_req_cyc", at, 12);

        // Redirect while waiting; the stale word must be dropped.
        apply_reset();
        mem_lat = 3;
        wait_req("t3_req0", a, at);
        step();
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0043;
        step();
        branch_taken = 1'b0;
        wait_req("t3_req1", a, at);
        check_output("t3_req1_addr", a, 32'h40);
        check_output("t3_req1_cyc", at, 5);
        wait_valid("t3_val", p, w, at);
        check_output("t3_pc", p, 32'h40);
        check_output("t3_ins", w, 32'hECE8_9B9F);
        mem_lat = 1;

        // Memory never answers: sticky error, no further requests.
        mem_on = 1'b0;
        apply_reset();
        wait_req("t4_req0", a, at);
        check_output("t4_req0_addr", a, 32'h0);
        err_at  = -1;
        req_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (fetch_err && (err_at < 0)) err_at = cyc;
            if (imem_req) req_cnt++;
        end
        check_output("t4_err_cyc", err_at, 18);
        check_output("t4_no_req", req_cnt, 0);
        check_output("t4_err_sticky", {31'd0, fetch_err}, 32'd1);
        mem_on = 1'b1;
        apply_reset();
        check_output("t4_err_cleared", {31'd0, fetch_err}, 32'd0);
        wait_req("t4_req_after", a, at);
        check_output("t4_req_after_addr", a, RESET_PC);

        // Redirect to the top word, then wrap on increment.
        apply_reset();
        wait_valid("t5_val0", p, w, at);
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0;
        check_output("t5_req_now", {31'd0, imem_req}, 32'd1);
        check_output("t5_req_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("t5_val1", p, w, at);
        check_output("t5_pc", p, 32'hFFFF_FFFC);
        check_output("t5_ins", w, 32'h1354_6423);
        wait_req("t5_wrap", a, at);
        check_output("t5_wrap_addr", a, 32'h0);

        // Reset in the middle of a wait, response lands during reset.
        apply_reset();
        mem_lat = 2;
        wait_req("t6_req0", a, at);
        step();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        end
        pend_addr.delete();
        pend_due.delete();
        imem_valid = 1'b0;
        reset_n    = 1'b1;
        cyc        = 0;
        wait_req("t6_req_after", a, at);
        check_output("t6_req_addr", a, RESET_PC);
        check_output("t6_req_cyc", at, 1);
        wait_valid("t6_val", p, w, at);
        check_output("t6_pc", p, RESET_PC);
        check_output("t6_val_cyc", at, 4);

        step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

endmodule
